// File: rtl/vote_pkg.sv
// vote_pkg: shared types and sizes for the ballot collection path
package vote_pkg;
  localparam int N_VOTERS = 4;
  localparam int VOTE_ID_W = 2;
  typedef enum logic [1:0] {IDLE, COLLECT, PRESENT} collect_state_t;
  typedef logic [N_VOTERS-1:0] ballot_t;
endpackage

// File: rtl/ballot_collector_if.sv
// ballot_collector_if: vote handshake, ballot presentation and status signals
interface ballot_collector_if;
  import vote_pkg::*;
  logic start;
  logic vote_valid;
  logic [VOTE_ID_W-1:0] vote_id;
  logic vote_val;
  logic vote_ready;
  ballot_t ballot;
  logic ballot_valid;
  logic ballot_ack;
  logic timed_out;
  logic dup_err;
  logic busy;
  modport master (
    output start, vote_valid, vote_id, vote_val, ballot_ack,
    input vote_ready, ballot, ballot_valid, timed_out, dup_err, busy
  );
  modport slave (
    input start, vote_valid, vote_id, vote_val, ballot_ack,
    output vote_ready, ballot, ballot_valid, timed_out, dup_err, busy
  );
endinterface

// File: rtl/ballot_collector_round_timer.sv
// round_timer: counts COLLECT cycles and flags the last permitted one
module round_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  logic [W-1:0] count;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clear) count <= '0;
    else if (enable) count <= count + 1'b1;
  assign expire = count == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/ballot_collector.sv
// ballot_collector: gathers one vote per voter per round and presents the ballot until acked
module ballot_collector
  import vote_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic clk,
  input logic rst,
  ballot_collector_if.slave bus
);
  collect_state_t state, state_nx;
  ballot_t cast_mask, ballot_r, new_mask;
  logic timed_out_r, dup_err_r, accept, fresh, complete, expire, open_round;
  assign open_round = state == IDLE && bus.start;
  assign accept = state == COLLECT && bus.vote_valid;
  assign fresh = accept && !cast_mask[bus.vote_id];
  assign new_mask = cast_mask | (fresh ? ballot_t'(1) << bus.vote_id : '0);
  // the final vote wins over a simultaneous timer expiry
  assign complete = fresh && new_mask == '1;
  round_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk), .rst(rst), .clear(open_round), .enable(state == COLLECT), .expire(expire)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE    ? (bus.start ? COLLECT : IDLE) :
               state == COLLECT ? (complete || expire ? PRESENT : COLLECT) :
                                  (bus.ballot_ack ? IDLE : PRESENT);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cast_mask <= '0;
      ballot_r <= '0;
      timed_out_r <= 1'b0;
      dup_err_r <= 1'b0;
    end else begin
      dup_err_r <= accept && cast_mask[bus.vote_id];
      if (open_round) begin
        cast_mask <= '0;
        ballot_r <= '0;
        timed_out_r <= 1'b0;
      end
      if (fresh) begin
        cast_mask <= new_mask;
        ballot_r[bus.vote_id] <= bus.vote_val;
      end
      if (state == COLLECT && expire && !complete) timed_out_r <= 1'b1;
    end
  assign bus.vote_ready = state == COLLECT;
  assign bus.ballot_valid = state == PRESENT;
  assign bus.busy = state != IDLE;
  assign bus.ballot = ballot_r;
  assign bus.timed_out = timed_out_r;
  assign bus.dup_err = dup_err_r;
endmodule

// File: tb/tb_ballot_collector.sv
// tb_ballot_collector: table-driven and randomized rounds checked against a round-level model
module tb_ballot_collector;
  import vote_pkg::*;
  localparam int TO = 16;
  typedef struct {
    logic [15:0] valid;
    logic [31:0] ids;
    logic [15:0] vals;
    logic [3:0]  ballot;
    logic        to;
    int          cycles;
    int          dups;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  ballot_collector_if bus();
  ballot_collector #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // first vote per voter counts; round ends when all four voted or the window closes
  function automatic vec_t model(input vec_t v);
    bit seen[4];
    int id;
    vec_t r = v;
    r.ballot = '0;
    r.dups = 0;
    r.cycles = TO;
    r.to = 1'b1;
    for (int c = 0; c < TO; c++) begin
      if (v.valid[c]) begin
        id = int'(v.ids[2*c +: 2]);
        if (seen[id]) r.dups++;
        else begin
          seen[id] = 1'b1;
          r.ballot[id] = v.vals[c];
        end
        if (seen[0] && seen[1] && seen[2] && seen[3]) begin
          r.cycles = c + 1;
          r.to = 1'b0;
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic run_round(input vec_t v, input int hold);
    int c = 0;
    int dups = 0;
    chk("idle_busy", bus.busy, 0);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk("collect_ready", bus.vote_ready, 1);
    chk("collect_busy", bus.busy, 1);
    chk("start_clears_ballot", bus.ballot, 0);
    while (!bus.ballot_valid && c < TO + 2) begin
      bus.vote_valid = c < TO ? v.valid[c] : 1'b0;
      bus.vote_id = c < TO ? v.ids[2*c +: 2] : 2'd0;
      bus.vote_val = c < TO ? v.vals[c] : 1'b0;
      bus.start = 1'($urandom_range(0, 1));
      bus.ballot_ack = 1'($urandom_range(0, 1));
      tick;
      if (bus.dup_err) dups++;
      c++;
    end
    bus.vote_valid = 1'b0;
    bus.ballot_ack = 1'b0;
    bus.start = 1'b0;
    chk("collect_cycles", c, v.cycles);
    chk("ballot", bus.ballot, v.ballot);
    chk("timed_out", bus.timed_out, v.to);
    chk("dup_pulses", dups, v.dups);
    chk("present_not_ready", bus.vote_ready, 0);
    for (int k = 0; k < hold; k++) begin
      bus.vote_valid = 1'($urandom_range(0, 1));
      bus.vote_id = 2'($urandom_range(0, 3));
      bus.vote_val = 1'($urandom_range(0, 1));
      bus.start = 1'b1;
      tick;
      chk("hold_ballot", bus.ballot, v.ballot);
      chk("hold_valid", bus.ballot_valid, 1);
      chk("hold_ready", bus.vote_ready, 0);
      chk("hold_timed_out", bus.timed_out, v.to);
    end
    bus.vote_valid = 1'b0;
    bus.start = 1'b0;
    bus.ballot_ack = 1'b1;
    tick;
    bus.ballot_ack = 1'b0;
    chk("ack_valid_drop", bus.ballot_valid, 0);
    chk("ack_idle", bus.busy, 0);
    chk("ballot_kept", bus.ballot, v.ballot);
  endtask

  vec_t vecs[5];
  vec_t rv;

  initial begin
    vecs[0] = '{16'h000F, 32'h000000E4, 16'h000D, 4'b1101, 1'b0, 4, 0};
    vecs[1] = '{16'h001F, 32'h0000034A, 16'h0001, 4'b0100, 1'b0, 5, 1};
    vecs[2] = '{16'h0001, 32'h00000001, 16'h0001, 4'b0010, 1'b1, 16, 0};
    vecs[3] = '{16'h8007, 32'hC0000024, 16'h8000, 4'b1000, 1'b0, 16, 0};
    vecs[4] = '{16'h0000, 32'h00000000, 16'h0000, 4'b0000, 1'b1, 16, 0};
    bus.start = 1'b0;
    bus.vote_valid = 1'b0;
    bus.vote_id = 2'd0;
    bus.vote_val = 1'b0;
    bus.ballot_ack = 1'b0;
    #3;
    chk("rst_ballot", bus.ballot, 0);
    chk("rst_valid", bus.ballot_valid, 0);
    chk("rst_ready", bus.vote_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_timed_out", bus.timed_out, 0);
    chk("rst_dup", bus.dup_err, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) run_round(vecs[i], 2);
    run_round(vecs[0], 20);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.vote_valid = 1'b1;
    bus.vote_id = 2'd0;
    bus.vote_val = 1'b1;
    tick;
    bus.vote_id = 2'd1;
    tick;
    bus.vote_valid = 1'b0;
    chk("partial_ballot", bus.ballot, 4'b0011);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ballot", bus.ballot, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_ready", bus.vote_ready, 0);
    chk("midrst_valid", bus.ballot_valid, 0);
    chk("midrst_timed_out", bus.timed_out, 0);
    chk("midrst_dup", bus.dup_err, 0);
    @(negedge clk);
    rst = 1'b0;
    rv = '{16'h000F, 32'h0000004E, 16'h0001, 4'b0100, 1'b0, 4, 0};
    run_round(rv, 0);
    for (int r = 0; r < 40; r++) begin
      rv.valid = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom & $urandom & $urandom);
      rv.ids = $urandom;
      rv.vals = 16'($urandom);
      rv = model(rv);
      run_round(rv, $urandom_range(0, 3));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
